// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, checks alignment,
// drives a single-beat memory access with lane placement of store data and
// byte strobes, extracts and extends load data, and returns a one-cycle
// response (data, alignment/size error, or timeout).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_*                 core request (valid/ready handshake) and fields
//   resp_*                one-cycle response strobe with rdata/error/timeout
//   stall                 core pipeline hold
//   mem_*                 memory request strobes, aligned address, lane data,
//                         byte strobes, and memory ack/read data
//   state_dbg             current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the request fields are latched on that edge and
// may change afterwards. req_ready is high only in IDLE. The memory side is
// a held-strobe protocol: one enable stays high until mem_valid is seen on
// an edge, and mem_valid is ignored whenever no enable is high.
module lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_error,
  output logic              resp_timeout,
  output logic              stall,
  output logic [XLEN-1:0]   mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [XLEN-1:0]   mem_write_data,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_read_data,
  output logic [1:0]        state_dbg
);

  localparam int XB   = XLEN / 8;
  localparam int OFFW = $clog2(XB);
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter value seen during the final allowed ACCESS cycle.
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            lat_write;
  logic            lat_unsigned;
  logic [1:0]      lat_size;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] res_rdata;
  logic            res_error;
  logic            res_timeout;

  logic [2:0]      req_mask;
  logic            req_bad;
  logic            timeout_hit;
  logic [3:0]      nbytes;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] repl;
  logic [XB-1:0]   strb_base;
  int              lane;

  // Alignment and size legality of the incoming request.
  always_comb begin
    req_mask = 3'b000;
    case (req_size)
      2'd0:    req_mask = 3'b000;
      2'd1:    req_mask = 3'b001;
      2'd2:    req_mask = 3'b011;
      default: req_mask = 3'b111;
    endcase
    req_bad = (|(req_addr[2:0] & req_mask)) || ((req_size == 2'd3) && (XLEN == 32));
  end

  // A zero TIMEOUT_CYCLES disables expiry entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == LAST);

  // Load extraction: move the addressed bytes to bit 0, then extend.
  always_comb begin
    shifted  = mem_read_data >> {lat_addr[OFFW-1:0], 3'b000};
    load_ext = shifted;
    case (lat_size)
      2'd0: load_ext = lat_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1: load_ext = lat_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2: load_ext = lat_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: load_ext = shifted;
    endcase
  end

  // Store placement: low 2^size bytes repeated in every lane, so the memory
  // only needs the strobes to pick the right ones.
  always_comb begin
    nbytes    = 4'd1 << lat_size;
    repl      = '0;
    lane      = 0;
    for (int i = 0; i < XB; i++) begin
      lane = i & (int'(nbytes) - 1);
      repl[8*i +: 8] = lat_wdata[8*lane +: 8];
    end
    // Shifting all-ones left by the byte count and inverting gives the
    // low-nbytes mask, and stays correct when nbytes equals the lane count.
    strb_base = ~({XB{1'b1}} << nbytes);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) state_next = req_bad ? DONE : ACCESS;
      end
      ACCESS: begin
        if (mem_valid || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch, counter and response capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'd0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      count        <= '0;
      res_rdata    <= '0;
      res_error    <= 1'b0;
      res_timeout  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            count        <= '0;
            res_rdata    <= '0;
            res_error    <= req_bad;
            res_timeout  <= 1'b0;
          end
        end
        ACCESS: begin
          // mem_valid on the expiry cycle still counts as a normal answer.
          if (mem_valid) begin
            res_rdata <= lat_write ? '0 : load_ext;
          end else if (timeout_hit) begin
            res_timeout <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    req_ready        = (state == IDLE);
    stall            = ((state == IDLE) && req_valid) || (state == ACCESS);
    mem_read_enable  = (state == ACCESS) && !lat_write;
    mem_write_enable = (state == ACCESS) && lat_write;
    mem_address      = (state == ACCESS) ? {lat_addr[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
    mem_write_data   = mem_write_enable ? repl : '0;
    mem_wstrb        = mem_write_enable ? (strb_base << lat_addr[OFFW-1:0]) : '0;
    resp_valid       = (state == DONE);
    resp_rdata       = (state == DONE) ? res_rdata : '0;
    resp_error       = (state == DONE) && res_error;
    resp_timeout     = (state == DONE) && res_timeout;
    state_dbg        = state;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: XLEN, 32, data/address width; legal values 32 or 64.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, max cycles in ACCESS awaiting mem_valid; 0 disables timeout.
REQ-003 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  core requests an access.
REQ-006 Port: req_ready  output  1  LSU can accept a request.
REQ-007 Port: req_write  input  1  1 = store, 0 = load.
REQ-008 Port: req_size  input  2  0 byte, 1 half, 2 word, 3 double.
REQ-009 Port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 Port: req_addr  input  XLEN  byte address.
REQ-011 Port: req_wdata  input  XLEN  store data, right-aligned.
REQ-012 Port: resp_valid  output  1  one-cycle response strobe.
REQ-013 Port: resp_rdata  output  XLEN  extended load result; 0 for stores/errors.
REQ-014 Port: resp_error  output  1  misaligned or illegal size.
REQ-015 Port: resp_timeout  output  1  memory did not answer in time.
REQ-016 Port: stall  output  1  core shall hold its pipeline.
REQ-017 Port: mem_address  output  XLEN  word/dword-aligned address (low log2(XLEN/8) bits zero).
REQ-018 Port: mem_read_enable / mem_write_enable  output  1 each  memory request strobes.
REQ-019 Port: mem_write_data  output  XLEN  lane-replicated store data.
REQ-020 Port: mem_wstrb  output  XLEN/8  byte-lane write enables.
REQ-021 Port: mem_valid  input  1  memory response/ack.
REQ-022 Port: mem_read_data  input  XLEN  full-width read data.

Function
REQ-023 FSM states IDLE, ACCESS, DONE; req_ready = (state == IDLE).
REQ-024 Handshake: request accepted on edge where req_valid && req_ready; address, size, write, unsigned, wdata latched.
REQ-025 Misaligned (addr mod 2^size != 0) or size 3 with XLEN=32: IDLE -> DONE directly, no mem enable ever asserted, resp_error=1.
REQ-026 Legal request: IDLE -> ACCESS; in ACCESS exactly one of mem_read_enable/mem_write_enable held high from latched request until mem_valid.
REQ-027 ACCESS + mem_valid: capture mem_read_data, -> DONE; minimum latency acceptance-to-resp_valid = 2 cycles.
REQ-028 Timeout counter cleared on entry to ACCESS, increments each ACCESS cycle without mem_valid; reaching TIMEOUT_CYCLES -> DONE with resp_timeout=1, enables drop; mem_valid in same cycle as expiry wins (normal response).
REQ-029 DONE: resp_valid=1 for exactly one cycle, unconditional -> IDLE; resp_* held stable only during that cycle, else 0.
REQ-030 mem_valid outside ACCESS ignored.
REQ-031 Store lanes: mem_write_data = req_wdata low 2^size bytes replicated across XLEN; mem_wstrb = ((1<<2^size)-1) << addr offset.
REQ-032 Load: select 2^size bytes at addr offset, sign- or zero-extend to XLEN.
REQ-033 stall = (state==IDLE && req_valid) || state==ACCESS; low in DONE so core advances with resp_valid.
REQ-034 Back-to-back: request held high is accepted in the IDLE cycle following DONE (one bubble).

Reset
REQ-035 reset asserted: next edge state=IDLE, counter=0, latched request cleared; all outputs 0 except req_ready=1.
REQ-036 Reset in ACCESS/DONE abandons transaction; no resp_valid issued for it.

Verification
REQ-037 XLEN=32, lb signed addr 0x103, mem_read_data 0x80FF_1234 -> mem_address 0x100, resp_rdata 0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-038 sh addr 0x2002, wdata 0x0000_ABCD -> mem_wstrb 4'b1100, mem_write_data 0xABCD_ABCD, mem_address 0x2000.
REQ-039 lw addr 0x6 -> resp_valid+resp_error one cycle after acceptance, mem enables never high, resp_rdata 0.
REQ-040 TIMEOUT_CYCLES=4, mem_valid held 0 -> enables high exactly 4 cycles, then resp_valid+resp_timeout.
REQ-041 reset pulsed during ACCESS -> next cycle req_ready=1, enables 0, no resp_valid.
REQ-042 XLEN=64, ld addr 0x8 with mem_valid same cycle as enable -> resp_valid 2 cycles after acceptance, full 64-bit data; second held request accepted one cycle later.
